// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end with a small prefetch queue.
// Issues one instruction-memory read at a time, queues the returned words
// together with their addresses, and flushes and refetches on a redirect.
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            request,
  output logic            we_re,
  output logic [3:0]      mask,
  output logic [XLEN-1:0] address_out,
  input  logic            imem_valid,
  input  logic [31:0]     instruction_fetch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] pc_out
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic [31:0]     r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc    [DEPTH];

  logic w_request;
  logic w_push;
  logic w_pop;
  logic w_out_valid;

  // A new fetch needs an idle port and a free slot for its response; the
  // count check counts the slot the outstanding response will occupy, so the
  // queue can never overflow.
  assign w_request   = (r_state == IDLE) && !stall && !redirect_valid &&
                       (r_count < FULL_CNT) && !rst;
  // Responses that arrive with a redirect are stale and never enter the queue.
  assign w_push      = (r_state == WAIT) && imem_valid && !redirect_valid;
  assign w_out_valid = (r_count != '0) && !rst;
  // A pop coinciding with a redirect is swallowed by the flush.
  assign w_pop       = w_out_valid && out_ready && !redirect_valid;

  assign request     = w_request;
  assign we_re       = 1'b0;
  assign mask        = 4'b1111;
  assign address_out = r_fetch_pc;
  assign out_valid   = w_out_valid;
  assign instruction = r_q_instr[r_rptr];
  assign pc_out      = r_q_pc[r_rptr];

  // Next-state logic for the single-outstanding-request tracker.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_request) w_state_next = WAIT;
      end
      WAIT: begin
        if (redirect_valid) w_state_next = imem_valid ? IDLE : DROP;
        else if (imem_valid) w_state_next = IDLE;
      end
      DROP: begin
        // The in-flight response belongs to the old path; swallow it.
        if (imem_valid) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding response outright.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Fetch address: redirect wins, otherwise advance by one word per request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_request) begin
      r_req_pc   <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  // Queue bookkeeping: a redirect empties the queue ahead of push and pop.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents need no reset because the count guards them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= instruction_fetch;
      r_q_pc[r_wptr]    <= r_req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized scoreboard bench for fetch_prefetch_unit.
// The stimulus process owns a memory model and an abstract view of the
// instruction stream (which words are still wanted and in what order); it
// queues expected {pc, instruction} pairs when a wanted response returns.
// A separate monitor compares every cycle and pops on each accepted output.
module tb_fetch_prefetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address_out;
  logic        imem_valid;
  logic [31:0] instruction_fetch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  fetch_prefetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .request(request), .we_re(we_re), .mask(mask), .address_out(address_out),
    .imem_valid(imem_valid), .instruction_fetch(instruction_fetch),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  item_t       exp_q[$];      // words the decoder should still receive, in order
  bit          outstanding;   // a read has been issued and not yet answered
  bit          pend_kept;     // that read is still on the current path
  logic [31:0] pend_addr;
  logic [31:0] model_pc;      // next address the program should fetch
  int          lat;
  bit          exp_req_seen;  // model decided a request was issued this cycle
  bit          done = 1'b0;

  // Stimulus knobs (percentages).
  bit          k_rst;
  int          p_stall, p_redir, p_ready, max_lat;
  bit          p_spur;
  bit          force_redir;
  logic [31:0] force_pc;

  // Monitor scratch.
  bit          m_ev, m_er;
  item_t       m_head;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model each cycle, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      m_ev = !rst && (exp_q.size() > 0);
      check("out_valid", 32'(out_valid), 32'(m_ev));
      check("we_re", 32'(we_re), 32'd0);
      check("mask", 32'(mask), 32'hF);
      m_er = !rst && !outstanding && !stall && !redirect_valid &&
             (exp_q.size() < DEPTH);
      check("request", 32'(request), 32'(m_er));
      if (m_er && request) check("address_out", address_out, model_pc);
      exp_req_seen = m_er;
      if (m_ev) begin
        m_head = exp_q[0];
        check("pc_out", pc_out, m_head.pc);
        check("instruction", instruction, m_head.ins);
        if (out_ready && !redirect_valid) begin
          void'(exp_q.pop_front());
          $display("POP pc=%h ins=%h", m_head.pc, m_head.ins);
        end
      end
    end
  end

  // Apply the effect of the clock edge that just happened to the model.
  task automatic update_model();
    item_t it;
    if (rst) begin
      exp_q.delete();
      outstanding = 1'b0;
      pend_kept   = 1'b0;
      model_pc    = RESET_PC;
    end else begin
      if (imem_valid && outstanding) begin
        outstanding = 1'b0;
        if (pend_kept && !redirect_valid) begin
          it.pc  = pend_addr;
          it.ins = mem_word(pend_addr);
          exp_q.push_back(it);
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        pend_kept = 1'b0;
        model_pc  = redirect_pc;
      end
      if (exp_req_seen) begin
        outstanding = 1'b1;
        pend_kept   = 1'b1;
        pend_addr   = model_pc;
        model_pc    = model_pc + 32'd4;
        lat         = int'($urandom_range(1, max_lat));
      end
    end
  endtask

  task automatic drive_inputs();
    rst = k_rst;
    if (outstanding) begin
      lat--;
      imem_valid = (lat == 0);
    end else begin
      imem_valid = p_spur && ($urandom_range(0, 15) == 0);
    end
    instruction_fetch = (imem_valid && outstanding) ? mem_word(pend_addr) : $urandom;
    stall     = ($urandom_range(0, 99) < p_stall);
    out_ready = ($urandom_range(0, 99) < p_ready);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else begin
      redirect_valid = !k_rst && ($urandom_range(0, 99) < p_redir);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4
                                                   : ($urandom & 32'h0000_0FFC);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      update_model();
      drive_inputs();
    end
  endtask

  // Stimulus: directed warm-up phases followed by randomized traffic.
  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; instruction_fetch = '0; out_ready = 1'b1;
    outstanding = 1'b0; pend_kept = 1'b0; pend_addr = '0; model_pc = RESET_PC;
    lat = 0; exp_req_seen = 1'b0;
    k_rst = 1'b1; p_stall = 0; p_redir = 0; p_ready = 100; max_lat = 1;
    p_spur = 1'b0; force_redir = 1'b0; force_pc = '0;

    run(3);                       // held in reset
    k_rst = 1'b0;
    run(20);                      // back-to-back fetch, one-cycle memory
    p_ready = 0;
    run(15);                      // queue fills to DEPTH, requests stop
    p_ready = 100;
    run(10);
    force_redir = 1'b1; force_pc = 32'h0000_0100; max_lat = 3;
    run(12);
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
    run(12);                      // address wraps through zero
    p_stall = 25; p_redir = 6; p_ready = 60; p_spur = 1'b1;
    run(1500);
    k_rst = 1'b1;
    run(2);                       // reset in the middle of traffic
    k_rst = 1'b0;
    run(500);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >= 2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port stall, input, 1, load pending in data memory; no new fetch request is issued while high.
REQ-007 SHALL have port redirect_valid, input, 1, taken branch, jal or jalr resolved this cycle.
REQ-008 SHALL have port redirect_pc, input, XLEN, target address of the redirect.
REQ-009 SHALL have port request, output, 1, instruction memory request strobe.
REQ-010 SHALL have port we_re, output, 1, constant 0 (read).
REQ-011 SHALL have port mask, output, 4, constant 4'b1111.
REQ-012 SHALL have port address_out, output, XLEN, fetch address, valid while request is high.
REQ-013 SHALL have port imem_valid, input, 1, instruction memory response valid.
REQ-014 SHALL have port instruction_fetch, input, 32, instruction memory response data.
REQ-015 SHALL have port out_valid, output, 1, queue head holds an instruction.
REQ-016 SHALL have port out_ready, input, 1, decode accepts head this cycle.
REQ-017 SHALL have port instruction, output, 32, head instruction.
REQ-018 SHALL have port pc_out, output, XLEN, address of head instruction.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-020 SHALL assert request combinationally only when state=IDLE, stall=0, redirect_valid=0, queue count < DEPTH, rst=0.
REQ-021 SHALL treat every asserted request as accepted that cycle; on accept: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (modulo 2^XLEN), state -> WAIT.
REQ-022 SHALL keep at most one request outstanding; imem_valid in IDLE is ignored.
REQ-023 SHALL, in WAIT with imem_valid=1 and redirect_valid=0, push {req_pc, instruction_fetch} into the queue and return to IDLE in the same edge.
REQ-024 SHALL present out_valid, instruction, pc_out from registered queue state; push-to-out_valid latency is one cycle, no bypass.
REQ-025 SHALL pop the head on out_valid && out_ready; simultaneous push and pop leaves count unchanged.
REQ-026 SHALL never overflow: the count < DEPTH check in REQ-020 reserves a slot for the outstanding response.
REQ-027 SHALL, on redirect_valid, empty the queue, set fetch_pc <= redirect_pc, and issue no request that cycle.
REQ-028 SHALL, on redirect_valid in WAIT with imem_valid=0, go to DROP; with imem_valid=1, discard the response and go to IDLE.
REQ-029 SHALL, in DROP, discard the next imem_valid response and return to IDLE; redirect in DROP only updates fetch_pc and stays in DROP.
REQ-030 SHALL give redirect priority over pop and push in the same cycle; a pop in that cycle has no further effect.
REQ-031 SHALL let stall block only new requests; an outstanding response still pushes, and pops continue.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, set fetch_pc=RESET_PC, state=IDLE, queue count=0, read/write pointers=0.
REQ-033 SHALL hold request=0 and out_valid=0 during reset; reset mid-WAIT abandons the outstanding response without entering DROP.

Verification
REQ-034 Reset release, memory answers 1 cycle after each request -> requests at 0x0,0x4,0x8; out_valid first high 2 cycles after the first request with pc_out=0x0.
REQ-035 out_ready=0, DEPTH=4 -> exactly 4 instructions queued (0x0..0xC), request stays 0 while count=4; one pop -> request to 0x10 next cycle.
REQ-036 Redirect to 0x100 while WAIT for 0x8, response arrives 2 cycles later -> response dropped, queue empty, next request address 0x100, first pc_out=0x100.
REQ-037 Redirect to 0x200 in the same cycle as imem_valid -> response not queued, state IDLE, next request to 0x200 the following cycle.
REQ-038 stall=1 for 3 cycles with one request outstanding -> response pushed, no new request during stall, request resumes the cycle stall falls.
REQ-039 fetch_pc=0xFFFF_FFFC, accepted request -> next address_out wraps to 0x0000_0000.
